clk_div_multi: RTL and testbench
================================

# clk_div_multi

Parametrised multi-channel clock divider, successor to the single fixed-ratio divider. It generates CHANNELS independent divided clocks from one system clock, each with a runtime-programmable period, per-channel enable, a single-cycle tick strobe, glitch-free divisor updates applied at period boundaries, and a global phase-align restart. It sits beside peripherals that need slow sample/baud/strobe clocks, such as loggers and timers, and replaces multiple fixed-ratio instances.

## Interface
- CHANNELS, 4: number of independent divider channels (1..16).
- WIDTH, 18: counter and divisor width in bits.
- DEFAULT_DIV, 8000: period, in clk_i cycles, loaded into every channel at reset. Must fit in WIDTH bits.
- clk_i  in  1  system clock. Everything is on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- en_i  in  CHANNELS  per-channel run enable. Low freezes that channel.
- sync_i  in  1  global restart: aligns all channels to a common rising edge.
- wr_i  in  1  divisor write strobe, one cycle.
- wr_ch_i  in  max(1,$clog2(CHANNELS))  target channel of the write.
- wr_div_i  in  WIDTH  new period D, in clk_i cycles.
- pending_o  out  CHANNELS  shadow divisor written but not yet active.
- clk_o  out  CHANNELS  divided clocks, registered.
- tick_o  out  CHANNELS  one-cycle strobe, coincident with each rising edge of clk_o.

## Operation
- Per channel state:
  - active divisor `div`
  - shadow divisor `shd`
  - `pend` flag
  - counter `cnt` (WIDTH bits)
  - registered `clk_o` and `tick_o`
- Effective period: E = max(div, 2). Values 0 and 1 are clamped to 2 and are never an error. H = E − (E>>1), so the high phase is ceil(E/2) cycles and the low phase is floor(E/2) cycles.
- Reset values:
  - div = shd = DEFAULT_DIV
  - pend = 0
  - cnt = E−1, the wrap position
  - clk_o = 0, tick_o = 0
  - pending_o = 0
- Enabled cycle (en_i[c]=1, sync_i=0):
  - If cnt == E−1: cnt←0, clk_o←1, tick_o←1. If pend is set, div←shd and pend←0 on this same edge, so the new E takes effect from this period onward.
  - Else: cnt←cnt+1 and tick_o←0. clk_o←0 when cnt+1 == H; otherwise clk_o holds.
- Disabled cycle (en_i[c]=0, sync_i=0): cnt and clk_o hold, tick_o←0, and any pending divisor stays pending.
- sync_i=1 applies to all channels regardless of en_i:
  - cnt←E'−1, where E' is computed from the divisor that becomes active (shd if pend is set, else div)
  - clk_o←0, tick_o←0
  - pending shadows are applied and pend←0
- After a sync, every enabled channel produces tick_o and a clk_o rise on the next enabled edge, all simultaneously.
- Write (wr_i=1, wr_ch_i<CHANNELS): shd[wr_ch_i]←wr_div_i and pend←1.
  - A write that arrives while a value is already pending overwrites it.
  - A write with wr_ch_i ≥ CHANNELS is ignored.
- A write on the same edge as an apply (wrap or sync) on the same channel: the previously pending value is applied to div, the new value is stored in shd, and pend stays 1.
- pending_o[c] = pend[c], driven directly from the register.

## Timing
- All outputs are registered with zero combinational paths from inputs. Single clock domain.
- Enable to first edge: reset release or sync, followed by en high at edge k, gives tick_o = 1 and clk_o = 1 after edge k.
- Steady state, period E:
  - tick_o high exactly 1 cycle in every E
  - clk_o high H cycles, low E−H cycles
  - no runt pulses
- Divisor write at edge w: pending_o = 1 after edge w. The new period starts at the first wrap or sync after w, and pending_o drops on that same edge.
- A write to a channel that never wraps (disabled) stays pending indefinitely until a wrap or sync.
- An asynchronous reset mid-period clears everything to the reset values immediately, without waiting for a clock edge.
- Lowering en_i mid-period stretches the current phase. Raising it again resumes from the frozen cnt.

## Test plan
- Reset values and default period: after reset with en_i = all ones, each clk_o is a 4000-high/4000-low square wave and tick_o pulses every 8000 cycles, with the first tick 1 cycle after en rises.
- Odd period and clamping: write 5 → high 3, low 2, tick every 5. Write 0 and 1 → period 2 (1 high, 1 low).
- Shadow update: on channel 0 with D = 10, write 4 at cnt = 3. The current period still completes as 10 cycles, then 4-cycle periods follow. pending_o[0] is high from the write until that wrap.
- Sync alignment: channels set to 6, 9 and 14, run for a random time, then pulse sync_i. All three tick_o pulse on the same cycle, 1 cycle after sync deasserts.
- Enable freeze and illegal write: drop en_i[1] for 7 cycles mid-high-phase and confirm the high phase is stretched by exactly 7 cycles. A write with wr_ch_i = CHANNELS must not change any pending_o bit.
- Simultaneous write and wrap: with 12 pending, write 20 on the wrap edge. The next period is 12 and pending_o stays high, then 20 applies at the following wrap.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel period, enable, tick strobe,
// shadowed divisor updates applied at period wrap, and a global phase-align restart.
module clk_div_multi #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 18,
    parameter int unsigned DEFAULT_DIV = 8000
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic [CHANNELS-1:0]                   en_i,
    input  logic                                  sync_i,
    input  logic                                  wr_i,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_ch_i,
    input  logic [WIDTH-1:0]                      wr_div_i,
    output logic [CHANNELS-1:0]                   pending_o,
    output logic [CHANNELS-1:0]                   clk_o,
    output logic [CHANNELS-1:0]                   tick_o
);

    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned DEF_EFF = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(DEF_EFF - 1);

    // Divisors below 2 cannot form a high and a low phase, so they clamp to 2.
    function automatic logic [WIDTH-1:0] eff_period(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? WIDTH'(2) : d;
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] div_q, div_d;
        logic [WIDTH-1:0] shd_q, shd_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             wr_hit;
        logic             wrap;
        logic             apply;
        logic [WIDTH-1:0] eff_cur;
        logic [WIDTH-1:0] eff_new;
        logic [WIDTH-1:0] half_cur;

        // Next-state: sync beats wrap beats count; a same-edge write lands in the shadow.
        always_comb begin
            div_d    = div_q;
            shd_d    = shd_q;
            cnt_d    = cnt_q;
            pend_d   = pend_q;
            clk_d    = clk_q;
            tick_d   = 1'b0;
            wr_hit   = wr_i && (wr_ch_i == CH_W'(g));
            eff_cur  = eff_period(div_q);
            half_cur = eff_cur - (eff_cur >> 1);
            wrap     = en_i[g] && (cnt_q == eff_cur - WIDTH'(1));
            apply    = sync_i || wrap;

            if (apply && pend_q) begin
                div_d = shd_q;
            end
            eff_new = eff_period(div_d);

            if (sync_i) begin
                cnt_d = eff_new - WIDTH'(1);
                clk_d = 1'b0;
            end else if (wrap) begin
                cnt_d  = '0;
                clk_d  = 1'b1;
                tick_d = 1'b1;
            end else if (en_i[g]) begin
                cnt_d = cnt_q + WIDTH'(1);
                if (cnt_q + WIDTH'(1) == half_cur) begin
                    clk_d = 1'b0;
                end
            end

            if (wr_hit) begin
                shd_d  = wr_div_i;
                pend_d = 1'b1;
            end else if (apply) begin
                pend_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                div_q  <= DEF_DIV;
                shd_q  <= DEF_DIV;
                cnt_q  <= RST_CNT;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                div_q  <= div_d;
                shd_q  <= shd_d;
                cnt_q  <= cnt_d;
                pend_q <= pend_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end

        assign pending_o[g] = pend_q;
        assign clk_o[g]     = clk_q;
        assign tick_o[g]    = tick_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (3 channels so an out-of-range write is expressible).
module tb_clk_div_multi;

    localparam int unsigned CH  = 3;
    localparam int unsigned W   = 18;
    localparam int unsigned DEF = 8000;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] en;
    logic          sync;
    logic          wr;
    logic [1:0]    wr_ch;
    logic [W-1:0]  wr_div;
    logic [CH-1:0] pending;
    logic [CH-1:0] clk_o;
    logic [CH-1:0] tick;

    int total = 0;
    int bad   = 0;

    clk_div_multi #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .en_i      (en),
        .sync_i    (sync),
        .wr_i      (wr),
        .wr_ch_i   (wr_ch),
        .wr_div_i  (wr_div),
        .pending_o (pending),
        .clk_o     (clk_o),
        .tick_o    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr_div_task(input int ch, input int d);
        wr     = 1'b1;
        wr_ch  = 2'(ch);
        wr_div = W'(d);
        @(negedge clk);
        wr     = 1'b0;
    endtask

    task automatic sync_pulse();
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
    endtask

    // Waits for a tick on ch, then counts high and low negedge samples up to the next rise.
    task automatic chk_period(input string tag, input int ch, input int exp_hi, input int exp_lo);
        int n;
        int hi;
        int lo;
        n  = 0;
        hi = 0;
        lo = 0;
        while (!tick[ch] && n < 20000) begin @(negedge clk); n++; end
        while (clk_o[ch] && n < 20000) begin hi++; @(negedge clk); n++; end
        while (!clk_o[ch] && n < 20000) begin lo++; @(negedge clk); n++; end
        check({tag, "_tmo"}, 32'(n < 20000), 1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_tick"}, 32'(tick[ch]), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;
        int lo;
        rst_n  = 1'b0;
        en     = '0;
        sync   = 1'b0;
        wr     = 1'b0;
        wr_ch  = '0;
        wr_div = '0;

        // Reset state and first edge after enable
        repeat (3) @(negedge clk);
        check("rst_clk", clk_o, 0);
        check("rst_tick", tick, 0);
        check("rst_pend", pending, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_clk", clk_o, 0);
        en = '1;
        @(negedge clk);
        check("first_tick", tick, 3'b111);
        check("first_clk", clk_o, 3'b111);
        chk_period("def", 0, 4000, 4000);

        // Odd period and clamping, applied by sync
        wr_div_task(0, 0);
        wr_div_task(1, 5);
        wr_div_task(2, 1);
        check("pend3", pending, 3'b111);
        sync_pulse();
        check("sync_clk", clk_o, 0);
        check("sync_tick", tick, 0);
        check("sync_pend", pending, 0);
        @(negedge clk);
        check("sync_first", tick, 3'b111);
        chk_period("clamp0", 0, 1, 1);
        chk_period("odd5", 1, 3, 2);
        chk_period("clamp1", 2, 1, 1);

        // Shadow update: period 10 finishes before 4 takes over
        wr_div_task(0, 10);
        sync_pulse();
        @(negedge clk);
        check("shd_tick", 32'(tick[0]), 1);
        repeat (3) @(negedge clk);
        wr_div_task(0, 4);
        check("shd_pend", 32'(pending[0]), 1);
        n = 4;
        while (!tick[0] && n < 50) begin
            if (n == 9) check("shd_pend_hold", 32'(pending[0]), 1);
            @(negedge clk);
            n++;
        end
        check("shd_len", n, 10);
        check("shd_pend_clr", 32'(pending[0]), 0);
        chk_period("shd4", 0, 2, 2);

        // Wrap-applied divisors, then sync alignment
        wr_div_task(0, 6);
        wr_div_task(1, 9);
        wr_div_task(2, 14);
        check("pend_multi", pending, 3'b111);
        repeat ($urandom_range(30, 60)) @(negedge clk);
        check("wrap_apply", pending, 0);
        sync_pulse();
        check("align_pre", tick, 0);
        @(negedge clk);
        check("align", tick, 3'b111);
        check("align_clk", clk_o, 3'b111);
        chk_period("p14", 2, 7, 7);
        chk_period("p9", 1, 5, 4);
        chk_period("p6", 0, 3, 3);

        // Enable freeze stretches the high phase of channel 1 (period 9)
        n = 0;
        while (!tick[1] && n < 50) begin @(negedge clk); n++; end
        hi = 1;
        @(negedge clk);
        hi += int'(clk_o[1]);
        en[1] = 1'b0;
        repeat (7) begin @(negedge clk); hi += int'(clk_o[1]); end
        en[1] = 1'b1;
        n = 0;
        while (clk_o[1] && n < 50) begin
            @(negedge clk);
            n++;
            if (clk_o[1]) hi++;
        end
        check("freeze_hi", hi, 12);
        lo = 0;
        while (!clk_o[1] && n < 50) begin lo++; @(negedge clk); n++; end
        check("freeze_lo", lo, 4);

        // Out-of-range channel write is ignored
        check("pend_pre_ill", pending, 0);
        wr_div_task(3, 7);
        check("ill_wr", pending, 0);

        // Write on the wrap edge while 12 is pending on channel 2 (period 14)
        n = 0;
        while (!tick[2] && n < 50) begin @(negedge clk); n++; end
        wr_div_task(2, 12);
        check("p12_pend", 32'(pending[2]), 1);
        repeat (12) @(negedge clk);
        check("pre_wrap_tick", 32'(tick[2]), 0);
        wr_div_task(2, 20);
        check("ww_tick", 32'(tick[2]), 1);
        check("ww_pend", 32'(pending[2]), 1);
        chk_period("ww12", 2, 6, 6);
        check("ww_pend_clr", 32'(pending[2]), 0);
        chk_period("ww20", 2, 10, 10);

        // Asynchronous reset mid-period
        wr_div_task(0, 30);
        check("arst_pre_clk", 32'(clk_o[2]), 1);
        check("arst_pre_pend", 32'(pending[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_clk", clk_o, 0);
        check("arst_pend", pending, 0);
        check("arst_tick", tick, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
